// File: rtl/gray_counter_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter_ctrl_if
//  Description : Control/status and counter-pin bundle for gray_counter_ctrl.
//                The slave side is the sequencer. The master side is whatever
//                drives the control inputs and hosts the Gray counter.
//  Revision    : 1.0  initial release
// ============================================================================
interface gray_counter_ctrl_if #(
    parameter int N      = 4,
    parameter int WRAP_W = 8
);
    // control side
    logic              start;
    logic              stop;
    logic              cont;
    logic [N-1:0]      start_value;
    logic [N-1:0]      end_value;
    logic              busy;
    logic              done;
    logic [WRAP_W-1:0] wraps;
    logic              err;
    // counter side
    logic              cnt_load;
    logic [N-1:0]      cnt_load_value;
    logic              cnt_enable;
    logic [N-1:0]      cnt_q;

    modport master (
        output start, stop, cont, start_value, end_value, cnt_q,
        input  busy, done, wraps, err, cnt_load, cnt_load_value, cnt_enable
    );

    modport slave (
        input  start, stop, cont, start_value, end_value, cnt_q,
        output busy, done, wraps, err, cnt_load, cnt_load_value, cnt_enable
    );
endinterface
`default_nettype wire

// File: rtl/gray_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter_ctrl
//  Description : Sequencer for a Gray counter. It loads a start code and
//                counts up to an end code, then stops or reloads. It also
//                flags any counter step that changes more than one bit.
//  Revision    : 1.0  initial release
// ============================================================================
module gray_counter_ctrl #(
    parameter int N      = 4,
    parameter int WRAP_W = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    gray_counter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [N-1:0]      r_sg;          // Gray start code
    logic [N-1:0]      r_eg;          // Gray end code
    logic [N-1:0]      r_q_prev;      // counter output from the previous cycle
    logic              r_cont;
    logic              r_after_load;  // previous cycle was LOAD
    logic              r_err;
    logic [WRAP_W-1:0] r_wraps;

    logic              w_match;
    logic              w_accept;
    logic              w_wrap;
    logic              w_multi_bit;
    logic [N-1:0]      w_diff;
    logic              w_load;
    logic              w_enable;
    logic              w_busy;
    logic              w_done;

    assign w_match  = (bus.cnt_q == r_eg);
    assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.stop;
    assign w_wrap   = (r_state == ST_RUN) && w_match && r_cont && !bus.stop;

    // Clearing the lowest set bit leaves a nonzero value only if two or more
    // bits differ.
    assign w_diff      = bus.cnt_q ^ r_q_prev;
    assign w_multi_bit = ((w_diff & (w_diff - N'(1))) != '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode. A stop overrides every other event in the
    // same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_enable    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load      = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_busy   = 1'b1;
                w_enable = !w_match;      // stop on the match, no overshoot
                if (w_match) begin
                    w_state_nxt = r_cont ? ST_LOAD : ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (bus.stop) begin
            w_state_nxt = ST_IDLE;
            w_load      = 1'b0;
            w_enable    = 1'b0;
            w_done      = 1'b0;
        end
    end

    // Sequence registers: latched codes, wrap count, transition monitor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sg         <= '0;
            r_eg         <= '0;
            r_q_prev     <= '0;
            r_cont       <= 1'b0;
            r_after_load <= 1'b0;
            r_err        <= 1'b0;
            r_wraps      <= '0;
        end else begin
            r_q_prev     <= bus.cnt_q;
            r_after_load <= (r_state == ST_LOAD);
            if (w_accept) begin
                r_sg    <= bus.start_value ^ (bus.start_value >> 1);
                r_eg    <= bus.end_value ^ (bus.end_value >> 1);
                r_cont  <= bus.cont;
                r_wraps <= '0;
                r_err   <= 1'b0;
            end else begin
                if (w_wrap && (r_wraps != '1)) begin
                    r_wraps <= r_wraps + WRAP_W'(1);
                end
                // The first RUN cycle follows a load jump, so it is not a
                // counting step and is skipped.
                if ((r_state == ST_RUN) && !r_after_load && w_multi_bit && !bus.stop) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.cnt_load       = w_load;
    assign bus.cnt_load_value = r_sg;
    assign bus.cnt_enable     = w_enable;
    assign bus.busy           = w_busy;
    assign bus.done           = w_done;
    assign bus.wraps          = r_wraps;
    assign bus.err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_counter_ctrl
//  Description : Scoreboard bench for gray_counter_ctrl with a behavioural
//                binary counter presenting Gray code on cnt_q.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gray_counter_ctrl;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int W2 = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gray_counter_ctrl_if #(.N(N), .WRAP_W(W))  bus  ();
    gray_counter_ctrl_if #(.N(N), .WRAP_W(W2)) bus2 ();

    gray_counter_ctrl #(.N(N), .WRAP_W(W))  u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    gray_counter_ctrl #(.N(N), .WRAP_W(W2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [N-1:0] from_gray(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural counters. The first one can skip binary 2 to plant a
    // two-bit Gray step (0001 -> 0010).
    logic [N-1:0] b1, b2;
    logic         glitch_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              b1 <= '0;
        else if (bus.cnt_load)   b1 <= from_gray(bus.cnt_load_value);
        else if (bus.cnt_enable) b1 <= (glitch_en && b1 == N'(1)) ? N'(3) : b1 + N'(1);
    end
    assign bus.cnt_q = to_gray(b1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)               b2 <= '0;
        else if (bus2.cnt_load)   b2 <= from_gray(bus2.cnt_load_value);
        else if (bus2.cnt_enable) b2 <= b2 + N'(1);
    end
    assign bus2.cnt_q = to_gray(b2);

    // Scoreboard queues
    typedef struct {
        int           t;
        logic [N-1:0] q;
        logic         err;
    } done_t;

    logic [N-1:0] load_q[$];
    done_t        done_q[$];
    logic [N-1:0] mon_lv;
    done_t        mon_d;

    // Monitor: each load or done pulse is matched against the oldest
    // expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cnt_load) begin
                if (load_q.size() == 0) begin
                    chk("spurious_load", 32'(bus.cnt_load), 32'd0);
                end else begin
                    mon_lv = load_q.pop_front();
                    chk("load_value", 32'(bus.cnt_load_value), 32'(mon_lv));
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    chk("spurious_done", 32'(bus.done), 32'd0);
                end else begin
                    mon_d = done_q.pop_front();
                    chk("done_time", 32'(cyc), 32'(mon_d.t));
                    chk("done_final_q", 32'(bus.cnt_q), 32'(mon_d.q));
                    chk("done_err", 32'(bus.err), 32'(mon_d.err));
                    chk("done_busy_low", 32'(bus.busy), 32'd0);
                end
            end
        end
    end

    // One sequence on the main DUT. One-shot: the counter advances
    // (e - s) mod 16 times and done arrives 3 + steps cycles after start.
    // Continuous: each lap is one load cycle plus steps + 1 run cycles, and
    // the stop lands on the load cycle after the last lap.
    task automatic run_seq(input logic [N-1:0] s, input logic [N-1:0] e, input logic c,
                           input int laps, input bit glitch);
        int    steps;
        int    t0;
        done_t d;
        steps = (int'(e) - int'(s) + 16) % 16;
        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.start_value = s;
        bus.end_value   = e;
        bus.cont        = c;
        t0              = cyc;
        if (!c) begin
            load_q.push_back(to_gray(s));
            d.t   = t0 + 3 + (glitch ? steps - 1 : steps);
            d.q   = to_gray(e);
            d.err = glitch;
            done_q.push_back(d);
        end else begin
            for (int i = 0; i < laps; i++) load_q.push_back(to_gray(s));
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_in_load", 32'(bus.busy), 32'd1);
        chk("err_cleared_on_start", 32'(bus.err), 32'd0);
        if (!c) begin
            repeat (steps + 4) @(posedge clk);
            #1;
        end else begin
            repeat (laps * (steps + 2)) @(posedge clk);
            #1;
            bus.stop = 1'b1;
            #1;
            chk("stop_blocks_load", 32'(bus.cnt_load), 32'd0);
            @(posedge clk); #1;
            bus.stop = 1'b0;
            chk("busy_after_stop", 32'(bus.busy), 32'd0);
            chk("wraps_after_stop", 32'(bus.wraps), 32'((laps > 255) ? 255 : laps));
        end
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.cont = 0; bus.start_value = '0; bus.end_value = '0;
        bus2.start = 0; bus2.stop = 0; bus2.cont = 0; bus2.start_value = '0; bus2.end_value = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({bus.cnt_load, bus.cnt_load_value, bus.cnt_enable,
                                  bus.busy, bus.done, bus.wraps, bus.err}), 32'd0);
        rst_n = 1'b1;

        // Plain one-shot, then one that wraps through 15 -> 0
        run_seq(4'd0, 4'd5, 1'b0, 0, 1'b0);
        run_seq(4'd14, 4'd1, 1'b0, 0, 1'b0);

        // Continuous, four laps, then stop
        run_seq(4'd2, 4'd4, 1'b1, 4, 1'b0);

        // Two-bit Gray step inside RUN
        glitch_en = 1'b1;
        run_seq(4'd0, 4'd6, 1'b0, 0, 1'b1);
        glitch_en = 1'b0;
        chk("err_sticky_in_idle", 32'(bus.err), 32'd1);

        // Stop on the end-code match; start during RUN is ignored
        @(posedge clk); #1;
        bus.start = 1'b1; bus.start_value = 4'd3; bus.end_value = 4'd7; bus.cont = 1'b0;
        load_q.push_back(to_gray(4'd3));
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.start_value = 4'd9; bus.end_value = 4'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("start_ignored_in_run", 32'(bus.cnt_load_value), 32'(to_gray(4'd3)));
        chk("still_busy_in_run", 32'(bus.busy), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("match_code_seen", 32'(bus.cnt_q), 32'(to_gray(4'd7)));
        bus.stop = 1'b1;
        #1;
        chk("enable_low_at_match", 32'(bus.cnt_enable), 32'd0);
        @(posedge clk); #1;
        bus.stop = 1'b0;
        chk("stop_wins_no_done", 32'(bus.done), 32'd0);
        chk("stop_wins_idle", 32'(bus.busy), 32'd0);

        // Randomized sequences
        for (int i = 0; i < 8; i++) begin
            run_seq(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), 1'b0, 0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            run_seq(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), 1'b1,
                    int'($urandom_range(1, 3)), 1'b0);
        end

        // Narrow wrap counter: start == end in continuous mode wraps every 2 cycles
        @(posedge clk); #1;
        bus2.start = 1'b1; bus2.start_value = 4'd5; bus2.end_value = 4'd5; bus2.cont = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("wraps2_first_lap", 32'(bus2.wraps), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("wraps2_saturated", 32'(bus2.wraps), 32'd3);
        @(posedge clk); #1;
        chk("dut2_busy_in_run", 32'(bus2.busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({bus2.cnt_load, bus2.cnt_load_value, bus2.cnt_enable,
                                        bus2.busy, bus2.done, bus2.wraps, bus2.err}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("idle_after_reset", 32'(bus2.busy), 32'd0);

        chk("load_queue_drained", 32'(load_q.size()), 32'd0);
        chk("done_queue_drained", 32'(done_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
